// File: rtl/timer_compare.sv
// rtl/timer_compare.sv - compare/interrupt unit behind the free-running timer, one-shot and periodic modes.
// Optional capture input is built when TIMER_CMP_CAPTURE_EN is defined.
module timer_compare #(
  parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  input  logic [31:0] timer_val,
  input  logic        cap_in,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic [31:0] tv_q;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        done_q, done_d;
  logic [31:0] cap_val;
  logic        capf_val;

  logic [2:0]  sel;
  logic        ctrl_wr, cmp_wr, per_wr, stat_wr;
  logic        hit, hit_eff;

  assign sel     = A[4:2];
  assign ctrl_wr = WE && (sel == 3'd0);
  assign cmp_wr  = WE && (sel == 3'd1);
  assign per_wr  = WE && (sel == 3'd2);
  assign stat_wr = WE && (sel == 3'd3);

  // Only a count change can hit, so a divided (held) count fires once.
  assign hit     = (timer_val == cmp_q) && (timer_val != tv_q) && (state_q == S_ARMED);
  assign hit_eff = hit && !(ctrl_wr && !WD[0]);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    done_d   = done_q;

    if (ctrl_wr) begin
      ctrl_d  = WD[2:0];
      state_d = WD[0] ? S_ARMED : S_IDLE;
      if (!WD[0]) done_d = 1'b0;
    end else if (hit) begin
      if (ctrl_q[1]) begin
        state_d = S_ARMED;
      end else begin
        state_d   = S_DONE;
        ctrl_d[0] = 1'b0;
        done_d    = 1'b1;
      end
    end

    if (cmp_wr)                      cmp_d = WD;
    else if (hit_eff && ctrl_q[1])   cmp_d = cmp_q + period_q;

    if (per_wr) period_d = WD;

    if (stat_wr && WD[0]) pend_d = 1'b0;
    if (stat_wr && WD[1]) ovr_d  = 1'b0;
    if (hit_eff) begin
      pend_d = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 3'd0;
      cmp_q    <= CMP_RST;
      period_q <= 32'd0;
      tv_q     <= 32'd0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      tv_q     <= timer_val;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      done_q   <= done_d;
    end
  end

`ifdef TIMER_CMP_CAPTURE_EN
  logic [2:0]  cap_sync_q;
  logic [31:0] cap_q;
  logic        capf_q;
  logic        unused_addr;

  assign unused_addr = ^A[1:0];

  // Two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sync_q <= 3'd0;
      cap_q      <= 32'd0;
      capf_q     <= 1'b0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], cap_in};
      if (cap_sync_q[1] && !cap_sync_q[2]) begin
        cap_q  <= timer_val;
        capf_q <= 1'b1;
      end else if (stat_wr && WD[3]) begin
        capf_q <= 1'b0;
      end
    end
  end

  assign cap_val  = cap_q;
  assign capf_val = capf_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{A[1:0], cap_in};
  assign cap_val       = 32'd0;
  assign capf_val      = 1'b0;
`endif

  always_comb begin
    RD = 32'd0;
    case (sel)
      3'd0:    RD = {29'd0, ctrl_q};
      3'd1:    RD = cmp_q;
      3'd2:    RD = period_q;
      3'd3:    RD = {28'd0, capf_val, done_q, ovr_q, pend_q};
      3'd4:    RD = cap_val;
      default: RD = 32'd0;
    endcase
  end

  assign irq = pend_q & ctrl_q[2];

endmodule

// File: tb/tb_timer_compare.sv
// tb/tb_timer_compare.sv - scoreboard bench for timer_compare: directed vectors, queued expectations.
module tb_timer_compare;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A = 5'd0;
  logic [31:0] WD = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] RD;
  logic [31:0] timer_val = 32'd0;
  logic        cap_in = 1'b0;
  logic        irq;

  timer_compare dut (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .timer_val(timer_val), .cap_in(cap_in), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_irq;
  } exp_t;

  exp_t sb_q[$];
  logic strobe = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [4:0] A_CTRL = 5'h00, A_CMP = 5'h04, A_PER = 5'h08,
                         A_STAT = 5'h0C, A_CAP = 5'h10;

  // Monitor: pops one expectation per presented sample.
  always @(negedge clk) begin
    if (strobe) begin
      exp_t e;
      logic [31:0] act;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL monitor: sample presented with empty scoreboard");
      end else begin
        e   = sb_q.pop_front();
        act = e.is_irq ? {31'd0, irq} : RD;
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    A = addr; WD = data; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic chk_rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.exp = exp; e.is_irq = 1'b0;
    A = addr;
    sb_q.push_back(e);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    exp_t e;
    e.name = name; e.exp = {31'd0, exp}; e.is_irq = 1'b1;
    sb_q.push_back(e);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic do_reset();
    timer_val = 32'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] v;
    do_reset();

    chk_rd(A_CMP,  32'hFFFF_FFFF, "reset_cmp");
    chk_rd(A_CTRL, 32'h0, "reset_ctrl");
    chk_irq(1'b0, "reset_irq");

    // One-shot at 5, count held 4 cycles per value.
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 8; i++) begin
      timer_val = i;
      for (int c = 0; c < 4; c++) begin
        if (i == 5 && c == 0)      chk_irq(1'b0, "oneshot_irq_before");
        else if (i == 5 && c == 1) chk_irq(1'b1, "oneshot_irq_after");
        else                       tick();
      end
    end
    chk_rd(A_CTRL, 32'h4, "oneshot_ctrl");
    chk_rd(A_STAT, 32'h5, "oneshot_status");

    // Periodic 10/20/30, PEND cleared after each hit.
    do_reset();
    wr(A_CMP, 32'd10);
    wr(A_PER, 32'd10);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i <= 35; i++) begin
      timer_val = i;
      tick();
      if (i == 10 || i == 20 || i == 30) begin
        chk_irq(1'b1, "periodic_irq");
        wr(A_STAT, 32'h1);
        chk_irq(1'b0, "periodic_irq_cleared");
      end
    end
    chk_rd(A_CMP, 32'd40, "periodic_cmp");
    chk_rd(A_STAT, 32'h0, "periodic_status");

    // Overrun: hits at 40 and 50 without clearing, then W1C colliding with hit at 60.
    for (int i = 36; i <= 50; i++) begin
      timer_val = i;
      tick();
    end
    chk_rd(A_STAT, 32'h3, "overrun_status");
    chk_rd(A_CMP, 32'd60, "overrun_cmp");
    timer_val = 32'd60;
    wr(A_STAT, 32'h1);
    chk_rd(A_STAT, 32'h3, "collision_status");
    chk_irq(1'b1, "collision_irq");
    chk_rd(A_CMP, 32'd70, "collision_cmp");

    // Wrap through 2^32.
    do_reset();
    wr(A_CMP, 32'hFFFF_FFF8);
    wr(A_PER, 32'h10);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 20; i++) begin
      v = 32'hFFFF_FFF6 + i;
      timer_val = v;
      tick();
      if (v == 32'hFFFF_FFF8) begin
        chk_irq(1'b1, "wrap_first_irq");
        wr(A_STAT, 32'h1);
      end
      if (v == 32'd0) chk_rd(A_CMP, 32'h8, "wrap_cmp");
      if (v == 32'd7) chk_irq(1'b0, "wrap_irq_at7");
      if (v == 32'd8) begin
        chk_irq(1'b1, "wrap_irq_at8");
        chk_rd(A_CMP, 32'h18, "wrap_cmp_next");
      end
    end

    // Asynchronous reset mid-cycle with irq asserted.
    #1;
    rst_n = 1'b0;
    chk_irq(1'b0, "async_reset_irq");
    chk_rd(A_CTRL, 32'h0, "rst_ctrl");
    chk_rd(A_CMP, 32'hFFFF_FFFF, "rst_cmp");
    chk_rd(A_PER, 32'h0, "rst_period");
    chk_rd(A_STAT, 32'h0, "rst_status");
    chk_rd(A_CAP, 32'h0, "rst_cap");
    rst_n = 1'b1;
    timer_val = 32'hFFFF_FFFF;
    tick();
    tick();
    chk_rd(A_STAT, 32'h0, "post_reset_no_hit");

    // Capture pin.
    timer_val = 32'h1234;
    tick();
    cap_in = 1'b1;
    tick(); tick(); tick();
`ifdef TIMER_CMP_CAPTURE_EN
    chk_rd(A_CAP, 32'h1234, "capture_value");
    chk_rd(A_STAT, 32'h8, "capture_flag");
`else
    chk_rd(A_CAP, 32'h0, "capture_value_off");
    chk_rd(A_STAT, 32'h0, "capture_flag_off");
`endif
    chk_irq(1'b0, "capture_irq");
    cap_in = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      miscompares += sb_q.size();
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_compare.md
# timer_compare

Compare/interrupt unit downstream of the free-running `timer` peripheral in the RISC-V microcontroller. Consumes the 32-bit timer count, matches it against a software-programmed compare value, and raises a level interrupt towards the core. Supports one-shot and periodic (auto-reload) modes. Registers are memory-mapped on the same simple `WD/WE/RD` data-bus port style as the other peripherals.

## Interface
- `CMP_RST`, default `32'hFFFF_FFFF`: reset value of the CMP register.
- `clk  input  1`: system clock. All state updates on the rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `A  input  5`: byte address within the block. `A[4:2]` selects the register; `A[1:0]` ignored.
- `WD  input  32`: write data.
- `WE  input  1`: write strobe; one write per cycle in which it is high.
- `RD  output  32`: read data, combinational from `A`.
- `timer_val  input  32`: current count from `timer`.
- `cap_in  input  1`: capture pin. Used only with the capture feature.
- `irq  output  1`: interrupt request, level, active-high.

## Operation
- Register map (offsets):
  - 0x00 CTRL: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE.
  - 0x04 CMP: compare value.
  - 0x08 PERIOD: reload increment.
  - 0x0C STATUS: [0] PEND, [1] OVR, [2] DONE, [3] CAPF. PEND, OVR and CAPF are write-1-to-clear; DONE is read-only.
  - 0x10 CAP: captured timer value (read-only).
- Undefined offsets read 0. Writes to them are ignored.
- `tv_q` is the registered copy of `timer_val`.
- Hit: `timer_val == CMP && timer_val != tv_q && state == ARMED`.
  - Matches only on a count change, so a count held for `F_DIV` cycles gives one hit.
  - Writing CMP equal to the current count does not hit until the count next reaches it.
- FSM states:
  - IDLE → ARMED on a CTRL write with EN=1.
  - ARMED → IDLE on a CTRL write with EN=0.
  - ARMED → DONE on a hit in one-shot mode. This clears CTRL.EN and sets STATUS.DONE.
  - ARMED → ARMED on a hit in periodic mode. This sets `CMP <= CMP + PERIOD` (mod 2^32, wraps silently).
  - DONE → ARMED on a CTRL write with EN=1.
  - DONE → IDLE on a CTRL write with EN=0. This clears DONE.
- On a hit: PEND ← 1. If PEND was already 1, OVR ← 1 as well.
- `irq = PEND & IE`.

## Timing
- Reset values:
  - CTRL = 0, CMP = `CMP_RST`, PERIOD = 0, STATUS = 0, CAP = 0, `tv_q` = 0.
  - State = IDLE, `irq` = 0.
  - All take effect immediately on `rst_n` low, independent of `clk`.
- Latency: `timer_val` reaches CMP in cycle N → PEND, `irq`, CMP reload and state change are visible in cycle N+1.
- Register writes are visible on `RD` the cycle after `WE`.
- Simultaneous events:
  - Hit and W1C of PEND in the same cycle: set wins, PEND stays 1.
  - Hit and CMP write in the same cycle: the bus value wins and the periodic reload is discarded. PEND is still set.
  - Hit and CTRL write with EN=0 in the same cycle: the hit is ignored; state goes to IDLE and PEND is unchanged.
  - Hit and CTRL write with EN=1 in the same cycle: the CTRL write wins for EN/MODE/IE; PEND is still set.
- Reset mid-operation: `irq` deasserts asynchronously. The first post-reset hit needs a CTRL write with EN=1.

## Configuration
- `TIMER_CMP_CAPTURE_EN` defined:
  - `cap_in` passes through a 2-FF synchronizer.
  - A synchronized rising edge latches `timer_val` into CAP and sets STATUS.CAPF. Latency is 3 cycles from the pin edge.
  - CAPF is a pending bit only; it does not drive `irq`.
- Macro undefined:
  - `cap_in` is ignored.
  - CAP and CAPF read 0.
  - No synchronizer flops are built.

## Test plan
- One-shot: CMP=5, CTRL=0x5; `timer_val` steps 0..7, each value held 4 cycles → PEND=1 and `irq`=1 exactly one cycle after `timer_val`=5. CTRL reads 0x4, STATUS reads 0x5, with no further hits.
- Periodic: CMP=10, PERIOD=10, CTRL=0x7; count to 35 → three hits (at 10, 20, 30) with PEND W1C'd after each. CMP reads 40. OVR=0.
- Overrun and collision: leave PEND set through a second hit → OVR=1. Write STATUS=0x1 in the same cycle as a third hit → PEND stays 1.
- Wrap: CMP=0xFFFF_FFF8, PERIOD=0x10, periodic; drive the count through 0xFFFF_FFFF → 0 → CMP reads 0x0000_0008. The next hit is at `timer_val`=8.
- Reset: `rst_n` low mid-cycle while ARMED with `irq`=1 → `irq`=0 before the next clock edge. All registers read their reset values.
- Capture (macro on): `cap_in` rises while `timer_val`=0x1234 is held → CAP=0x1234 and CAPF=1 within 3 cycles. `irq` is unchanged.
